tmds_encoder_8b10b: RTL
=======================

Name: tmds_encoder_8b10b

Overview:
- Single-channel DVI 1.0 TMDS 8b/10b encoder.
- Sits between the video timing driver (video_rgb/hs/vs/de) and the 10:1 serializer inside the HDMI transmitter. Three instances are used: blue carries hsync/vsync on c0/c1; green and red carry c=00.
- Pipelined, with a fixed latency and a running-disparity counter that provides DC balance during active video.

Parameters:
- CNT_W, 5: width of the signed running-disparity counter. Range −16..+15 covers the reachable −8..+8.
- RST_CODE, 10'b1101010100: dout value under reset. This is the c=00 control token.

Ports:
- pixel_clk  input  1  pixel clock; all logic on the rising edge.
- sys_rst_n  input  1  reset; synchronous, active-low, sampled on the pixel_clk rising edge.
- din        input  8  pixel component (one of R/G/B).
- c0         input  1  control bit 0 (hsync on blue channel).
- c1         input  1  control bit 1 (vsync on blue channel).
- de         input  1  data enable; 1 = active video, 0 = blanking/control.
- dout       output 10 TMDS symbol; bit 0 is transmitted first by the serializer.

Behaviour:
- Reset (sys_rst_n=0 at a rising edge):
  - All pipeline registers are cleared.
  - Disparity counter cnt = 0.
  - dout = RST_CODE.
  - Applies at any time, including mid-line. The first post-reset symbol is treated as cnt=0.
- Latency: inputs sampled at edge N produce dout after edge N+2. Throughput is one symbol per clock with no stalls.
- Stage 1 (edge N): register din, de, c0, c1 and n1d = popcount(din) (4 bits).
- Stage 2 (edge N+1): register q_m[8:0], n1q = popcount(q_m[7:0]), n0q = 8 − n1q, plus delayed de/c0/c1.
  - Use XNOR if n1d>4, or if n1d==4 and din[0]==0. Otherwise use XOR.
  - Chain: q_m[0]=din[0]; q_m[i] = q_m[i−1] (op) din[i] for i=1..7.
  - q_m[8] = 0 for XNOR, 1 for XOR.
- Stage 3 (edge N+2), when de=1 (all cnt arithmetic is signed, width CNT_W):
  - If cnt==0 or n1q==n0q:
    - dout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1q−n0q) : (n0q−n1q).
  - Else if (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - dout = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0q−n1q).
  - Else:
    - dout = {0, q_m[8], q_m[7:0]}.
    - cnt += (n1q−n0q) − 2*(~q_m[8]).
- Stage 3, when de=0: cnt = 0, and dout is selected by {c1,c0}:
  - 00 → 10'b1101010100
  - 01 → 10'b0010101011
  - 10 → 10'b0101010100
  - 11 → 10'b1010101011
- Boundaries:
  - A de 1→0 transition clears cnt on that same symbol.
  - On de 0→1, the first data symbol starts with cnt=0.
  - din is ignored while de=0.
  - c0/c1 are ignored while de=1.
  - cnt never leaves −8..+8. A value outside this range is a design error (assertion).

Decomposition:
- Shared package tmds_pkg:
  - CTRL_TOKEN_00/01/10/11 constants.
  - TMDS_SYM_W=10.
  - popcount8 function.
- One natural sub-module, tmds_qm_stage: stages 1–2 (popcount, XOR/XNOR transition minimisation), purely pipelined with no state beyond its registers. The top module holds the disparity stage and the control mux.

Test Plan:
- Reset: hold sys_rst_n=0 for 3 clocks with random inputs → dout=10'h354 every cycle and cnt=0. Release → first valid symbol appears 3 edges after the first sampled input.
- de=1, din=0x00 ×3 from cnt=0 → dout 0x100 (cnt −8), then 0x3FF (cnt +2), then 0x100 (cnt −6).
- de=1, din=0xFF from cnt=0 → q_m=0_FF (XNOR), dout=0x200, cnt=−8.
- de=0, {c1,c0} = 00, 01, 10, 11 consecutively → dout 0x354, 0x0AB, 0x154, 0x2AB at latency 3. Preceding nonzero cnt is cleared.
- Assert sys_rst_n=0 for one cycle mid-active-line with cnt≠0 → next dout=0x354. After release, cnt restarts at 0; a reference model matches.
- Random 640×480 frame (de/c0/c1 from timing, random din) → bit-exact match with a behavioural DVI 1.0 encoder model. |cnt| ≤ 8 throughout. Decoding each symbol recovers din.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, control tokens, the stage-2 pipeline word
// and the popcount helper used by the transition-minimisation stage.
package tmds_pkg;

   localparam int TMDS_SYM_W = 10;

   localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

   // Transition-minimised word plus its ones/zeros counts and delayed control.
   typedef struct packed {
      logic [8:0] q_m;
      logic [3:0] n1q;
      logic [3:0] n0q;
      logic       de;
      logic       c0;
      logic       c1;
   } qm_word_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stages 1-2 of the TMDS encoder: input register with popcount, then the
// XOR/XNOR transition-minimisation chain registered together with its counts.
module tmds_qm_stage
   import tmds_pkg::*;
(
   input  logic       pixel_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] i_din,
   input  logic       i_de,
   input  logic       i_c0,
   input  logic       i_c1,
   output qm_word_t   o_qm
);

   logic [7:0] r_din;
   logic [3:0] r_n1d;
   logic       r_de;
   logic       r_c0;
   logic       r_c1;
   logic       w_use_xnor;
   logic [8:0] w_qm;
   qm_word_t   r_qm;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pixel_clk) begin
      if (!sys_rst_n) begin
         r_din <= '0;
         r_n1d <= '0;
         r_de  <= 1'b0;
         r_c0  <= 1'b0;
         r_c1  <= 1'b0;
      end else begin
         r_din <= i_din;
         r_n1d <= popcount8(i_din);
         r_de  <= i_de;
         r_c0  <= i_c0;
         r_c1  <= i_c1;
      end
   end

   assign w_use_xnor = (r_n1d > 4'd4) || ((r_n1d == 4'd4) && !r_din[0]);

   // NOTE: the chain is built in a block-local variable assigned before use, so no latch and no self-loop on w_qm.
   always_comb begin
      logic [7:0] v_chain;
      v_chain    = '0;
      v_chain[0] = r_din[0];
      for (int i = 1; i < 8; i++) begin
         v_chain[i] = w_use_xnor ? ~(v_chain[i-1] ^ r_din[i]) : (v_chain[i-1] ^ r_din[i]);
      end
      w_qm = {~w_use_xnor, v_chain};
   end

   always_ff @(posedge pixel_clk) begin
      if (!sys_rst_n) begin
         r_qm <= '0;
      end else begin
         r_qm.q_m <= w_qm;
         r_qm.n1q <= popcount8(w_qm[7:0]);
         r_qm.n0q <= 4'd8 - popcount8(w_qm[7:0]);
         r_qm.de  <= r_de;
         r_qm.c0  <= r_c0;
         r_qm.c1  <= r_c1;
      end
   end

   assign o_qm = r_qm;

endmodule

// File: rtl/tmds_encoder_8b10b.sv
// DVI 1.0 TMDS 8b/10b channel encoder: q_m pipeline, then the DC-balancing
// disparity stage and the control-token mux. Two-edge latency, one symbol per clock.
module tmds_encoder_8b10b
   import tmds_pkg::*;
#(
   parameter int                    CNT_W    = 5,
   parameter logic [TMDS_SYM_W-1:0] RST_CODE = CTRL_TOKEN_00
)(
   input  logic                  pixel_clk,
   input  logic                  sys_rst_n,
   input  logic [7:0]            din,
   input  logic                  c0,
   input  logic                  c1,
   input  logic                  de,
   output logic [TMDS_SYM_W-1:0] dout
);

   localparam logic signed [CNT_W-1:0] CNT_MAX = CNT_W'(8);
   localparam logic signed [CNT_W-1:0] CNT_MIN = -CNT_MAX;

   qm_word_t                w_qm;
   logic signed [CNT_W-1:0] r_cnt;
   logic signed [CNT_W-1:0] w_cnt_nxt;
   logic signed [CNT_W-1:0] w_bal;
   logic signed [CNT_W-1:0] w_two_qm8;
   logic signed [CNT_W-1:0] w_two_nqm8;
   logic [TMDS_SYM_W-1:0]   r_dout;
   logic [TMDS_SYM_W-1:0]   w_dout_nxt;
   logic                    w_cnt_zero;
   logic                    w_cnt_pos;
   logic                    w_cnt_neg;

   tmds_qm_stage u_qm_stage (
      .pixel_clk (pixel_clk),
      .sys_rst_n (sys_rst_n),
      .i_din     (din),
      .i_de      (de),
      .i_c0      (c0),
      .i_c1      (c1),
      .o_qm      (w_qm)
   );

   assign w_bal      = CNT_W'(w_qm.n1q) - CNT_W'(w_qm.n0q);
   assign w_two_qm8  = w_qm.q_m[8] ? CNT_W'(2) : '0;
   assign w_two_nqm8 = w_qm.q_m[8] ? '0 : CNT_W'(2);
   assign w_cnt_zero = (r_cnt == '0);
   assign w_cnt_neg  = r_cnt[CNT_W-1];
   assign w_cnt_pos  = !w_cnt_zero && !w_cnt_neg;

   // NOTE: both outputs get a default first so every path assigns them and no latch is inferred.
   always_comb begin
      w_dout_nxt = RST_CODE;
      w_cnt_nxt  = '0;
      if (!w_qm.de) begin
         unique case ({w_qm.c1, w_qm.c0})
            2'b00:   w_dout_nxt = CTRL_TOKEN_00;
            2'b01:   w_dout_nxt = CTRL_TOKEN_01;
            2'b10:   w_dout_nxt = CTRL_TOKEN_10;
            default: w_dout_nxt = CTRL_TOKEN_11;
         endcase
      end else if (w_cnt_zero || (w_qm.n1q == w_qm.n0q)) begin
         w_dout_nxt = {~w_qm.q_m[8], w_qm.q_m[8],
                       w_qm.q_m[8] ? w_qm.q_m[7:0] : ~w_qm.q_m[7:0]};
         w_cnt_nxt  = w_qm.q_m[8] ? (r_cnt + w_bal) : (r_cnt - w_bal);
      end else if ((w_cnt_pos && (w_qm.n1q > w_qm.n0q)) ||
                   (w_cnt_neg && (w_qm.n0q > w_qm.n1q))) begin
         w_dout_nxt = {1'b1, w_qm.q_m[8], ~w_qm.q_m[7:0]};
         w_cnt_nxt  = r_cnt + w_two_qm8 - w_bal;
      end else begin
         w_dout_nxt = {1'b0, w_qm.q_m[8], w_qm.q_m[7:0]};
         w_cnt_nxt  = r_cnt + w_bal - w_two_nqm8;
      end
   end

   // NOTE: reset is synchronous, sampled only on the pixel_clk rising edge.
   always_ff @(posedge pixel_clk) begin
      if (!sys_rst_n) begin
         r_cnt  <= '0;
         r_dout <= RST_CODE;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_dout <= w_dout_nxt;
      end
   end

   assign dout = r_dout;

   a_cnt_in_range : assert property (@(posedge pixel_clk) disable iff (!sys_rst_n)
      (r_cnt >= CNT_MIN) && (r_cnt <= CNT_MAX));

endmodule
